uart_tx_fifo_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 72 +++++++
 rtl/uart_tx_fifo_ctrl.sv | 133 +++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width, default
// buffer sizing and the FIFO controller state encoding.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_TIMEOUT_CYC = 8192;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separately maintained occupancy counter.
// The head entry is presented combinationally from the storage array
// (rd_data = mem[rd_ptr]), so a pop consumes the byte already visible.
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              push_s;
  logic              pop_s;

  // Full/empty come from the registered count; strobes are qualified so
  // an illegal push or pop can never corrupt the pointers.
  assign full    = (count_r == FULL_CNT);
  assign empty   = (count_r == '0);
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];
  assign push_s  = push && !full;
  assign pop_s   = pop && !empty;

  // Storage array write port; contents are cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer advance with natural wrap and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Buffered front end for uart_tx: queues system-side bytes and launches
// them one frame at a time over the start/busy/done handshake, with a
// watchdog that abandons a frame whose done pulse never arrives.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  output logic                   tx_timeout,
  output logic                   uart_tx_start,
  output logic [UART_DATA_W-1:0] uart_tx_data,
  input  logic                   uart_tx_busy,
  input  logic                   uart_tx_done
);

  localparam int            WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  tx_state_e              state_r, state_n;
  logic [WD_W-1:0]        wd_r, wd_n;
  logic                   start_r, start_n;
  logic [UART_DATA_W-1:0] data_r, data_n;
  logic                   timeout_r, timeout_n;
  logic                   overflow_r;
  logic                   pop_s;
  logic [UART_DATA_W-1:0] head_s;

  sync_fifo #(
    .WIDTH  (UART_DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_en),
    .pop     (pop_s),
    .wr_data (wr_data),
    .rd_data (head_s),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign uart_tx_start = start_r;
  assign uart_tx_data  = data_r;
  assign tx_timeout    = timeout_r;
  assign overflow      = overflow_r;

  // Flag a write that arrived while the registered full flag was set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= wr_en && full;
    end
  end

  // FSM, watchdog and launch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      wd_r      <= '0;
      start_r   <= 1'b0;
      data_r    <= '0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      wd_r      <= wd_n;
      start_r   <= start_n;
      data_r    <= data_n;
      timeout_r <= timeout_n;
    end
  end

  // Next-state logic: launch from IDLE when the transmitter is free, chain
  // back-to-back on done, and give up when the watchdog expires.
  always_comb begin
    state_n   = state_r;
    wd_n      = wd_r;
    start_n   = 1'b0;
    data_n    = data_r;
    timeout_n = 1'b0;
    pop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty && !uart_tx_busy) begin
          pop_s   = 1'b1;
          start_n = 1'b1;
          data_n  = head_s;
          wd_n    = '0;
          state_n = WAIT_DONE;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_DONE: begin
        if (uart_tx_done) begin
          wd_n = '0;
          if (!empty) begin
            pop_s   = 1'b1;
            start_n = 1'b1;
            data_n  = head_s;
            state_n = WAIT_DONE;
          end else begin
            state_n = IDLE;
          end
        end else if (wd_r == WD_LAST) begin
          timeout_n = 1'b1;
          wd_n      = '0;
          state_n   = IDLE;
        end else begin
          wd_n = wd_r + WD_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        wd_n    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Scoreboard bench for uart_tx_fifo_ctrl with a behavioural transmitter
// (fixed-length frame, optional "never done" mode for the watchdog).
module tb_uart_tx_fifo_ctrl;

  localparam int FRAME = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_timeout, uart_tx_start;
  logic [4:0] count;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy, uart_tx_done;

  logic       hold;
  logic       hang;
  logic       busy_m, done_m;
  logic [7:0] cnt_m;

  int         vectors    = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo_ctrl #(
    .DEPTH(16), .ADDR_W(4), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_timeout(tx_timeout), .uart_tx_start(uart_tx_start),
    .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
    .uart_tx_done(uart_tx_done)
  );

  always #5 clk = ~clk;

  assign uart_tx_busy = busy_m | hold;
  assign uart_tx_done = done_m;

  // Behavioural transmitter: busy for FRAME cycles after a start, then done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m <= 1'b0;
      done_m <= 1'b0;
      cnt_m  <= 8'd0;
    end else begin
      done_m <= 1'b0;
      if (uart_tx_start && !hang) begin
        busy_m <= 1'b1;
        cnt_m  <= 8'(FRAME);
      end else if (busy_m) begin
        if (cnt_m == 8'd1) begin
          busy_m <= 1'b0;
          done_m <= 1'b1;
        end
        cnt_m <= cnt_m - 8'd1;
      end
    end
  end

  // Monitor: every launch pops the scoreboard and compares the byte.
  initial begin
    logic prev_start;
    logic [7:0] e;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_tx_start) begin
        vectors++;
        if (prev_start) begin
          miscompares++;
          $display("FAIL start_double: start high two cycles running, required single-cycle pulse");
        end else if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL start_unexpected: got launch of %02h, required no launch", uart_tx_data);
        end else begin
          e = exp_q.pop_front();
          if (uart_tx_data !== e) begin
            miscompares++;
            $display("FAIL tx_data: got %02h required %02h", uart_tx_data, e);
          end
        end
      end
      prev_start = uart_tx_start;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clk);
    if (accept) exp_q.push_back(b);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (uart_tx_done) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s: got no done within 300 cycles, required done", name);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    chk({name, "_drained"}, exp_q.size(), 0);
    wait_done(name);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_full"}, full, 1'b0);
    chk({name, "_empty"}, empty, 1'b1);
    chk({name, "_count"}, count, 5'd0);
    chk({name, "_overflow"}, overflow, 1'b0);
    chk({name, "_timeout"}, tx_timeout, 1'b0);
    chk({name, "_start"}, uart_tx_start, 1'b0);
    chk({name, "_data"}, uart_tx_data, 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; hold = 1'b0; hang = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single byte, two-cycle launch latency
    @(posedge clk); #1;
    wr(8'hA5, 1'b1);
    @(negedge clk);
    chk("t1_empty_after_write", empty, 1'b0);
    chk("t1_no_start_yet", uart_tx_start, 1'b0);
    @(negedge clk);
    chk("t1_start", uart_tx_start, 1'b1);
    wait_done("t1_done");
    @(negedge clk);
    chk("t1_empty_end", empty, 1'b1);
    chk("t1_no_restart", uart_tx_start, 1'b0);
    repeat (5) @(negedge clk);

    // 2: burst of four, count peaks at 3, back-to-back launches
    for (int i = 1; i <= 4; i++) wr(8'(i), 1'b1);
    @(negedge clk);
    chk("t2_count_peak", count, 5'd3);
    for (int i = 0; i < 3; i++) begin
      wait_done("t2_done");
      @(negedge clk);
      chk("t2_b2b_start", uart_tx_start, 1'b1);
    end
    wait_done("t2_last_done");
    @(negedge clk);
    chk("t2_idle_start", uart_tx_start, 1'b0);
    chk("t2_empty", empty, 1'b1);

    // 3: fill while busy held, 17th write overflows
    hold = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i), 1'b1);
    @(negedge clk);
    chk("t3_full", full, 1'b1);
    chk("t3_count16", count, 5'd16);
    chk("t3_no_ovf_yet", overflow, 1'b0);
    wr(8'hEE, 1'b0);
    @(negedge clk);
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_count_hold", count, 5'd16);
    @(negedge clk);
    chk("t3_overflow_pulse", overflow, 1'b0);
    hold = 1'b0;
    drain("t3");
    @(negedge clk);

    // 4: simultaneous write and launch at count 5
    hold = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) wr(8'h31 + 8'(i), 1'b1);
    @(negedge clk);
    chk("t4_count5", count, 5'd5);
    hold = 1'b0;
    wr(8'h36, 1'b1);
    @(negedge clk);
    chk("t4_count_same", count, 5'd5);
    chk("t4_no_overflow", overflow, 1'b0);
    chk("t4_launched", uart_tx_start, 1'b1);
    drain("t4");
    @(negedge clk);

    // 5: transmitter never completes, watchdog abandons each frame
    hang = 1'b1;
    @(posedge clk); #1;
    wr(8'h41, 1'b1);
    wr(8'h42, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (uart_tx_start) seen = 1'b1;
    end
    chk("t5_first_start", seen, 1'b1);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (tx_timeout) seen = 1'b1;
    end
    chk("t5_timeout_seen", seen, 1'b1);
    chk("t5_timeout_delay", n, 100);
    @(negedge clk);
    chk("t5_timeout_pulse", tx_timeout, 1'b0);
    chk("t5_relaunch", uart_tx_start, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (tx_timeout) seen = 1'b1;
    end
    chk("t5_second_timeout", seen, 1'b1);
    hang = 1'b0;
    @(negedge clk);
    chk("t5_empty", empty, 1'b1);

    // 6: reset mid-frame with three bytes queued
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) wr(8'h51 + 8'(i), 1'b1);
    repeat (5) @(negedge clk);
    chk("t6_count3", count, 5'd3);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_vals("t6_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (uart_tx_start) seen = 1'b1;
    end
    chk("t6_no_start_after_reset", seen, 1'b0);
    @(posedge clk); #1;
    wr(8'h5A, 1'b1);
    drain("t6");

    repeat (5) @(negedge clk);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
